// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: stages UART receiver bytes, tags late frame errors and queues them in a FIFO
module uart_rx_buffer #(
   parameter int Depth       = 8,
   parameter int CommitDelay = 32
) (
   input  logic                    clk,
   input  logic                    nReset,
   input  logic [7:0]              rxData,
   input  logic                    rxDone,
   input  logic                    rxErr,
   output logic [7:0]              outData,
   output logic                    outFrameErr,
   output logic                    outValid,
   input  logic                    outReady,
   output logic [$clog2(Depth):0]  count,
   output logic                    overrun,
   input  logic                    clearOverrun,
   output logic [7:0]              orphanErrs
);
   localparam int AW = $clog2(Depth);
   localparam int TW = $clog2(CommitDelay);
   localparam logic [TW-1:0] TLOAD = TW'(CommitDelay - 1);

   logic          r_done_dly;
   logic          r_err_prev;
   logic          r_pend_valid;
   logic [7:0]    r_pend_byte;
   logic [TW-1:0] r_pend_timer;
   logic [AW:0]   r_wr_ptr;
   logic [AW:0]   r_rd_ptr;
   logic          r_overrun;
   logic [7:0]    r_orphan;
   logic [8:0]    r_mem [Depth];

   logic          w_done_ev;
   logic          w_err_ev;
   logic          w_commit;
   logic          w_full;
   logic          w_pop;
   logic          w_push;
   logic          w_drop;
   logic [8:0]    w_head;

   assign w_done_ev   = r_done_dly;
   assign w_err_ev    = rxErr & ~r_err_prev;
   assign w_commit    = r_pend_valid & (w_err_ev | w_done_ev | (r_pend_timer == '0));
   assign w_full      = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) & (r_wr_ptr[AW] != r_rd_ptr[AW]);
   assign outValid    = r_wr_ptr != r_rd_ptr;
   assign w_pop       = outValid & outReady;
   assign w_push      = w_commit & (~w_full | w_pop);
   assign w_drop      = w_commit & w_full & ~w_pop;
   assign w_head      = r_mem[r_rd_ptr[AW-1:0]];
   assign outData     = outValid ? w_head[7:0] : 8'h00;
   assign outFrameErr = outValid & w_head[8];
   assign count       = r_wr_ptr - r_rd_ptr;
   assign overrun     = r_overrun;
   assign orphanErrs  = r_orphan;

   // Event detection and staging register; a new byte overrides any clear from an error commit
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         r_done_dly   <= 1'b0;
         r_err_prev   <= 1'b0;
         r_pend_valid <= 1'b0;
         r_pend_byte  <= 8'h00;
         r_pend_timer <= '0;
      end else begin
         r_done_dly <= rxDone;
         r_err_prev <= rxErr;
         if (w_done_ev) begin
            r_pend_valid <= 1'b1;
            r_pend_byte  <= rxData;
            r_pend_timer <= TLOAD;
         end else if (w_commit) begin
            r_pend_valid <= 1'b0;
         end else if (r_pend_valid) begin
            r_pend_timer <= r_pend_timer - 1'b1;
         end
      end
   end

   // FIFO storage; the error tag is taken from the same-cycle error event
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {w_err_ev, r_pend_byte};
   end

   // FIFO pointers, sticky overrun (set beats clear) and saturating orphan-error counter
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_overrun <= 1'b0;
         r_orphan  <= 8'h00;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_drop) r_overrun <= 1'b1;
         else if (clearOverrun) r_overrun <= 1'b0;
         if (w_err_ev && !r_pend_valid && r_orphan != 8'hFF) r_orphan <= r_orphan + 1'b1;
      end
   end
endmodule
